// File: rtl/pe_feeder_pkg.sv
// pe_feeder_pkg: shared read-FSM type and sizing constants for the PE operand feeder
package pe_feeder_pkg;
  localparam int MAX_K_DEF = 5;
  localparam int DEPTH_DEF = MAX_K_DEF * MAX_K_DEF;
  localparam int CNT_W     = 8;
  typedef enum logic [1:0] {R_IDLE, R_IPSUM, R_STREAM, R_OPSUM} rd_state_t;
  function automatic int idx_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/pe_act_bank.sv
// pe_act_bank: one ping-pong bank holding a window of KK activations plus its ipsum
//   i_clr      clears fill state (config)       i_rel     clears fill state (read done)
//   i_kk       activations per window            i_rd_idx  read index into the window
//   i_act_we/i_act_data, i_ips_we/i_ips_data     write strobes, only asserted when room
//   o_act_room/o_ips_room  bank can take more    o_full    complete window held
//   o_done     last item arrives this cycle      o_act/o_ipsum  read data
module pe_act_bank
  import pe_feeder_pkg::*;
#(
  parameter int ACT_W  = 8,
  parameter int PSUM_W = 24,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  input  logic                i_rel,
  input  logic [CNT_W-1:0]    i_kk,
  input  logic [idx_w(DEPTH)-1:0] i_rd_idx,
  input  logic                i_act_we,
  input  logic [ACT_W-1:0]    i_act_data,
  input  logic                i_ips_we,
  input  logic [PSUM_W-1:0]   i_ips_data,
  output logic                o_act_room,
  output logic                o_ips_room,
  output logic                o_full,
  output logic                o_done,
  output logic [ACT_W-1:0]    o_act,
  output logic [PSUM_W-1:0]   o_ipsum
);
  localparam int IW = idx_w(DEPTH);
  logic [ACT_W-1:0]  r_mem [DEPTH];
  logic [PSUM_W-1:0] r_ipsum;
  logic [CNT_W-1:0]  r_cnt, w_cnt_n;
  logic              r_ips_got, r_full, w_ips_n, w_done;
  assign w_cnt_n    = r_cnt + CNT_W'(i_act_we);
  assign w_ips_n    = r_ips_got | i_ips_we;
  // full is registered in the same edge that takes the final item
  assign w_done     = !r_full && w_ips_n && w_cnt_n == i_kk;
  assign o_act_room = !r_full && r_cnt < i_kk;
  assign o_ips_room = !r_full && !r_ips_got;
  assign o_full     = r_full;
  assign o_done     = w_done;
  assign o_act      = r_mem[i_rd_idx];
  assign o_ipsum    = r_ipsum;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt     <= '0;
      r_ips_got <= 1'b0;
      r_full    <= 1'b0;
    end else if (i_clr || i_rel) begin
      r_cnt     <= '0;
      r_ips_got <= 1'b0;
      r_full    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_n;
      r_ips_got <= w_ips_n;
      r_full    <= r_full | w_done;
    end
  always_ff @(posedge clk) begin
    if (i_act_we) r_mem[r_cnt[IW-1:0]] <= i_act_data;
    if (i_ips_we) r_ipsum <= i_ips_data;
  end
endmodule

// File: rtl/pe_operand_feeder.sv
// pe_operand_feeder: buffers weights and ping-pong activation windows, replays the PE sequence
//   cfg_start/kernel_size/cfg_err   configuration and invalid-K flag
//   wt_*  weight stream (K*K beats)   act_*  window activations   ips_*  window ipsum
//   pe_ready/pe_ipsum/pe_act/pe_wt    PE-side interface           busy  read FSM active
module pe_operand_feeder
  import pe_feeder_pkg::*;
#(
  parameter int ACT_W  = 8,
  parameter int WT_W   = 8,
  parameter int PSUM_W = 24,
  parameter int MAX_K  = MAX_K_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [7:0]        kernel_size,
  output logic              cfg_err,
  input  logic              wt_valid,
  output logic              wt_ready,
  input  logic [WT_W-1:0]   wt_data,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic [ACT_W-1:0]  act_data,
  input  logic              ips_valid,
  output logic              ips_ready,
  input  logic [PSUM_W-1:0] ips_data,
  output logic              pe_ready,
  output logic [PSUM_W-1:0] pe_ipsum,
  output logic [ACT_W-1:0]  pe_act,
  output logic [WT_W-1:0]   pe_wt,
  output logic              busy
);
  localparam int DEPTH = MAX_K * MAX_K;
  localparam int IW    = idx_w(DEPTH);
  rd_state_t        r_state, w_state_n;
  logic [CNT_W-1:0] r_kk, r_wcnt, r_idx;
  logic             r_cfg_err, r_loading, r_wl, r_rd_sel, r_wr_sel;
  logic [WT_W-1:0]  r_wt [DEPTH];
  logic             w_cfg, w_k_bad, w_last, w_wt_fire;
  logic [1:0]       w_full, w_done, w_act_room, w_ips_room;
  logic [ACT_W-1:0] w_act [2];
  logic [PSUM_W-1:0] w_ipsum [2];
  assign w_cfg     = cfg_start && r_state == R_IDLE;
  assign w_k_bad   = kernel_size == '0 || kernel_size > CNT_W'(MAX_K);
  assign w_wt_fire = wt_valid && r_loading;
  assign w_last    = r_state == R_STREAM && r_idx == r_kk - 1'b1;
  assign wt_ready  = r_loading;
  assign act_ready = r_wl && w_act_room[r_wr_sel];
  assign ips_ready = r_wl && w_ips_room[r_wr_sel];
  assign cfg_err   = r_cfg_err;
  for (genvar b = 0; b < 2; b++) begin : g_bank
    pe_act_bank #(.ACT_W(ACT_W), .PSUM_W(PSUM_W), .DEPTH(DEPTH)) u_bank (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (w_cfg),
      .i_rel      (w_last && r_rd_sel == 1'(b)),
      .i_kk       (r_kk),
      .i_rd_idx   (r_idx[IW-1:0]),
      .i_act_we   (act_valid && act_ready && r_wr_sel == 1'(b)),
      .i_act_data (act_data),
      .i_ips_we   (ips_valid && ips_ready && r_wr_sel == 1'(b)),
      .i_ips_data (ips_data),
      .o_act_room (w_act_room[b]),
      .o_ips_room (w_ips_room[b]),
      .o_full     (w_full[b]),
      .o_done     (w_done[b]),
      .o_act      (w_act[b]),
      .o_ipsum    (w_ipsum[b])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_kk      <= '0;
      r_cfg_err <= 1'b0;
      r_loading <= 1'b0;
      r_wl      <= 1'b0;
      r_wcnt    <= '0;
      r_wr_sel  <= 1'b0;
    end else if (w_cfg) begin
      r_kk      <= kernel_size * kernel_size;
      r_cfg_err <= w_k_bad;
      r_loading <= !w_k_bad;
      r_wl      <= 1'b0;
      r_wcnt    <= '0;
      r_wr_sel  <= 1'b0;
    end else begin
      if (w_wt_fire) begin
        r_wcnt <= r_wcnt + 1'b1;
        if (r_wcnt == r_kk - 1'b1) begin
          r_loading <= 1'b0;
          r_wl      <= 1'b1;
        end
      end
      // only the write bank can complete, so any done flips the writer
      if (|w_done) r_wr_sel <= !r_wr_sel;
    end
  always_ff @(posedge clk)
    if (w_wt_fire) r_wt[r_wcnt[IW-1:0]] <= wt_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= R_IDLE;
      r_idx    <= '0;
      r_rd_sel <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= r_state == R_STREAM ? r_idx + 1'b1 : '0;
      if (w_cfg) r_rd_sel <= 1'b0;
      else if (w_last) r_rd_sel <= !r_rd_sel;
    end
  // a config pulse wins over starting a window, since it empties the banks
  always_comb
    w_state_n = r_state == R_IPSUM  ? R_STREAM :
                r_state == R_STREAM ? (w_last ? R_OPSUM : R_STREAM) :
                (w_full[r_rd_sel] && !w_cfg) ? R_IPSUM : R_IDLE;
  always_comb begin
    pe_ready = (r_state == R_IDLE || r_state == R_OPSUM) && w_full[r_rd_sel] && !w_cfg;
    pe_ipsum = r_state == R_IPSUM ? w_ipsum[r_rd_sel] : '0;
    pe_act   = r_state == R_STREAM ? w_act[r_rd_sel] : '0;
    pe_wt    = r_state == R_STREAM ? r_wt[r_idx[IW-1:0]] : '0;
    busy     = r_state != R_IDLE;
  end
endmodule

// File: tb/tb_pe_operand_feeder.sv
// tb_pe_operand_feeder: randomized self-checking bench with a window-schedule reference model
module tb_pe_operand_feeder;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cfg_start = 1'b0, wt_valid = 1'b0, act_valid = 1'b0, ips_valid = 1'b0;
  logic [7:0]  kernel_size = '0, wt_data = '0, act_data = '0;
  logic [23:0] ips_data = '0;
  logic        cfg_err, wt_ready, act_ready, ips_ready, pe_ready, busy;
  logic [23:0] pe_ipsum;
  logic [7:0]  pe_act, pe_wt;
  always #5 clk = ~clk;
  pe_operand_feeder dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .kernel_size(kernel_size), .cfg_err(cfg_err),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .ips_valid(ips_valid), .ips_ready(ips_ready), .ips_data(ips_data),
    .pe_ready(pe_ready), .pe_ipsum(pe_ipsum), .pe_act(pe_act), .pe_wt(pe_wt), .busy(busy)
  );
  int nvec = 0, nerr = 0, cyc = 0;
  int kk = 0, wcnt = 0, ndone = 0, acnt = 0, maxw = 0;
  bit err = 0, loading = 0, loaded = 0, ipsg = 0;
  int R[64];
  logic [7:0]  wexp[25];
  logic [7:0]  wa[64][25];
  logic [23:0] wi[64];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask
  // Window m is announced at R[m], ipsum at R[m]+1, pairs over the next kk cycles,
  // OPSUM at R[m]+kk+2; its bank is writable again from R[m]+kk+2.
  task automatic step(input bit feed, input int pv, input bit seq, input bit do_cfg, input logic [7:0] k);
    logic [23:0] e_ips;
    logic [7:0]  e_act, e_wt;
    bit e_rdy, e_busy, e_ar, e_ir, fr;
    int p, kv;
    @(negedge clk);
    e_ips = '0; e_act = '0; e_wt = '0; e_rdy = 0; e_busy = 0;
    for (int m = 0; m < ndone; m++) begin
      if (R[m] == cyc) e_rdy = 1;
      if (R[m] + 1 == cyc) e_ips = wi[m];
      p = cyc - R[m] - 2;
      if (p >= 0 && p < kk) begin e_act = wa[m][p]; e_wt = wexp[p]; end
      if (cyc > R[m] && cyc <= R[m] + kk + 2) e_busy = 1;
    end
    fr = (ndone < 2) ? 1'b1 : (cyc >= R[ndone-2] + kk + 2);
    e_ar = loaded && acnt < kk && fr;
    e_ir = loaded && !ipsg && fr;
    chk("pe_ready", pe_ready, e_rdy);
    chk("pe_ipsum", pe_ipsum, e_ips);
    chk("pe_act", pe_act, e_act);
    chk("pe_wt", pe_wt, e_wt);
    chk("busy", busy, e_busy);
    chk("act_ready", act_ready, e_ar);
    chk("ips_ready", ips_ready, e_ir);
    chk("wt_ready", wt_ready, loading);
    chk("cfg_err", cfg_err, err);
    cfg_start   = do_cfg;
    kernel_size = k;
    wt_valid    = feed && $urandom_range(99) < pv;
    wt_data     = seq ? 8'(wcnt + 1) : 8'($urandom);
    act_valid   = feed && ndone < maxw && $urandom_range(99) < pv;
    act_data    = seq ? 8'(10 + ndone * kk + acnt) : 8'($urandom);
    ips_valid   = feed && ndone < maxw && $urandom_range(99) < pv;
    ips_data    = seq ? 24'(100 + ndone) : 24'($urandom);
    if (do_cfg && !e_busy) begin
      kv = int'(k);
      kk = (kv * kv) & 255; err = kv == 0 || kv > 5; loading = !err; loaded = 0;
      wcnt = 0; ndone = 0; acnt = 0; ipsg = 0;
    end else begin
      if (wt_valid && loading) begin
        wexp[wcnt] = wt_data; wcnt++;
        if (wcnt == kk) begin loading = 0; loaded = 1; end
      end
      if (act_valid && e_ar) begin wa[ndone][acnt] = act_data; acnt++; end
      if (ips_valid && e_ir) begin wi[ndone] = ips_data; ipsg = 1; end
      if (loaded && acnt == kk && ipsg) begin
        R[ndone] = (ndone == 0) ? cyc + 1 :
                   ((cyc + 1 > R[ndone-1] + kk + 2) ? cyc + 1 : R[ndone-1] + kk + 2);
        ndone++; acnt = 0; ipsg = 0;
      end
    end
    cyc++;
  endtask
  task automatic run(input logic [7:0] k, input int nw, input int pv, input bit seq, input int ncyc);
    maxw = nw;
    step(0, 0, 0, 1, k);
    for (int i = 0; i < ncyc; i++) step(1, pv, seq, 0, 0);
    chk("windows", ndone, nw);
    chk("drained", cyc > R[nw-1] + kk + 2, 1);
  endtask
  task automatic wait_stream(input int idx);
    int n = 0;
    while (!(ndone > 0 && cyc == R[0] + 2 + idx) && n < 300) begin
      step(1, 100, 1, 0, 0);
      n++;
    end
    chk("reach_idx", n < 300, 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) step(0, 0, 0, 0, 0);
    run(3, 2, 100, 1, 60);
    run(3, 4, 100, 1, 100);
    run(5, 8, 60, 0, 600);
    run(1, 6, 50, 0, 200);
    run(4, 10, 90, 0, 400);
    maxw = 2;
    step(0, 0, 0, 1, 3);
    wait_stream(3);
    step(1, 100, 1, 1, 2);
    for (int i = 0; i < 60; i++) step(1, 100, 1, 0, 0);
    chk("cfg_ignored_windows", ndone, 2);
    step(0, 0, 0, 1, 3);
    wait_stream(4);
    @(negedge clk);
    chk("pre_rst_act", pe_act, wa[0][4]);
    rst = 1'b1; act_valid = 0; ips_valid = 0; wt_valid = 0; cfg_start = 0;
    #1;
    chk("rst_ready", pe_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_act", pe_act, 0);
    chk("rst_wt", pe_wt, 0);
    chk("rst_act_ready", act_ready, 0);
    chk("rst_wt_ready", wt_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    loading = 0; loaded = 0; err = 0; ndone = 0; acnt = 0; ipsg = 0; wcnt = 0; kk = 0;
    cyc += 2;
    for (int i = 0; i < 5; i++) step(1, 100, 0, 0, 0);
    run(2, 3, 80, 0, 150);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 100, 0, 0, 0);
    step(0, 0, 0, 1, 6);
    for (int i = 0; i < 5; i++) step(1, 100, 0, 0, 0);
    run(2, 5, 70, 0, 200);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/pe_operand_feeder.md
Name: pe_operand_feeder

Overview:
- Sits directly upstream of the PE and its PE controller.
- Loads a K×K weight set once, then buffers incoming activation windows, each with its input partial sum, in two ping-pong banks.
- Advertises READY to the PE controller only when a complete window is held.
- Replays the controller's IDLE/IPSUM/OP/OPSUM sequence internally, so it drives ipsum and the K*K act/weight pairs on exactly the cycles the PE consumes them, with no PE-side stalls.

Parameters:
- ACT_W, 8, activation width
- WT_W, 8, weight width
- PSUM_W, 24, partial-sum width
- MAX_K, 5, largest supported kernel_size; buffer depth per bank and weights = MAX_K*MAX_K

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- cfg_start  in  1  pulse: latch kernel_size, clear banks, begin weight load
- kernel_size  in  8  K, sampled only on cfg_start
- cfg_err  out  1  latched kernel_size invalid (0 or >MAX_K)
- wt_valid/wt_ready/wt_data  in/out/in  1/1/WT_W  weight stream, row-major, K*K beats
- act_valid/act_ready/act_data  in/out/in  1/1/ACT_W  window activation stream, K*K beats per window
- ips_valid/ips_ready/ips_data  in/out/in  1/1/PSUM_W  one input psum per window
- pe_ready  out  1  READY to the PE controller
- pe_ipsum  out  PSUM_W  valid in the IPSUM cycle
- pe_act  out  ACT_W  valid in OP cycles
- pe_wt  out  WT_W  valid in OP cycles
- busy  out  1  read FSM not in R_IDLE

Behaviour:
- Reset: all outputs 0; weights_loaded=0; both banks empty; rd_sel=wr_sel=0; FSMs idle. Reset mid-window aborts it silently.
- cfg_start is honoured only when the read FSM is in R_IDLE, otherwise ignored. When honoured:
  - Latch K and compute KK=K*K as an 8-bit value.
  - Clear weights_loaded, banks and pointers.
  - If K==0 or K>MAX_K: set cfg_err=1, keep all readies 0. cfg_err is cleared only by the next valid cfg_start.
- Weight load:
  - wt_ready=1 while loading and cfg_err=0.
  - Beat i writes wt[i]. After beat KK-1, weights_loaded=1 and wt_ready=0. Extra weight beats are not accepted.
- Write side, for bank wr_sel while weights_loaded and the bank is not full:
  - act_ready=1 until KK activations have been taken.
  - ips_ready=1 until one ipsum has been taken. The two streams are independent; both may fire in the same cycle.
  - The bank becomes full the cycle after its last item arrives; wr_sel then toggles.
  - With both banks full, act_ready=ips_ready=0.
- Read FSM (R_IDLE, R_IPSUM, R_STREAM, R_OPSUM):
  - R_IDLE: pe_ready=full[rd_sel], combinational. If 1, go to R_IPSUM.
  - R_IPSUM: pe_ipsum=ipsum[rd_sel]. Go to R_STREAM with idx=0.
  - R_STREAM: pe_act=act[rd_sel][idx], pe_wt=wt[idx], idx increments each cycle. At idx==KK-1: clear full[rd_sel], toggle rd_sel, go to R_OPSUM.
  - R_OPSUM: pe_ready=full[rd_sel] (the other bank). If 1, go to R_IPSUM (back-to-back); else go to R_IDLE.
  - pe_ready is 0 in R_IPSUM and R_STREAM. pe_* data outputs are 0 outside their valid state.
- Latency: READY to first pair is 2 cycles. One window occupies KK+2 cycles including IPSUM and OPSUM.
- A bank released in R_STREAM may be refilled from the next cycle. A write to the bank being read is impossible, since full gating blocks it.
- Width: idx and fill counters are 8 bits. KK ≤ MAX_K² by construction.

Decomposition:
- Package pe_feeder_pkg: read-state enum, MAX_K-derived depth constant, counter width constant.
- One sub-module, pe_act_bank: a single bank holding KK activations, an ipsum register, a fill counter and a full flag. Instantiate twice.
- Weight store and both FSMs live in the top.

Test Plan:
1. K=3: load weights 1..9, one window of acts 10..18, ipsum 100. Required: pe_ready=1 → next cycle pe_ipsum=100 → 9 cycles of pairs (10,1)…(18,9) → OPSUM with pe_ready=0 → R_IDLE.
2. K=3, two windows preloaded. Required: pe_ready=1 in R_OPSUM, and the second window's IPSUM follows immediately (windows are 11 cycles apart).
3. K=0 and K=6 on cfg_start. Required: cfg_err=1, wt_ready=act_ready=pe_ready=0. A following cfg_start with K=2 clears cfg_err.
4. Both banks full while the first is streaming. Required: act_ready=0 until the cycle after the bank releases at idx 8.
5. rst asserted mid-R_STREAM (idx=4). Required: all outputs 0 asynchronously, banks empty, weights must be reloaded.
6. cfg_start during R_STREAM. Required: ignored; the current window completes with unchanged K.
